// File: rtl/master_mode_controller.sv
// master_mode_controller
// Master-mode trigger generator on the output side of the timer trigger
// fabric. It picks an internal event or level according to mms_i and drives
// trg_o towards slave timers. Pulse-type events become programmable-width
// pulses, each followed by a guaranteed one-cycle low gap. Events that arrive
// while a pulse is in flight are queued in a saturating counter. An event lost
// at saturation sets a sticky overflow flag.
//
// Ports
//   clk_i          timer kernel clock
//   srst_i         synchronous reset, active-high
//   mms_i          master mode select (000 reset, 001 enable, 010 update,
//                  011 compare pulse, 100..111 OCxREF levels)
//   msm_i          adds one extra output register stage when set
//   pw_i           trigger pulse high time minus one, in clk_i cycles
//   ug_i           software update generation pulse
//   cen_i          counter enable level
//   uev_i          update event pulse
//   ccif_i         capture/compare interrupt flags (levels)
//   ocref_i        output compare reference levels
//   trg_ovf_clr_i  clears trg_ovf_o
//   trg_o          trigger output (TRGO)
//   trg_busy_o     pulse engine active or events pending
//   trg_ovf_o      sticky flag: an event was lost at a saturated queue
module master_mode_controller #(
  parameter int CH_PAIRS_NUM = 2,
  parameter int PULSE_W      = 4,
  parameter int CNT_W        = 3
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [2:0]                mms_i,
  input  logic                      msm_i,
  input  logic [PULSE_W-1:0]        pw_i,
  input  logic                      ug_i,
  input  logic                      cen_i,
  input  logic                      uev_i,
  input  logic [2*CH_PAIRS_NUM-1:0] ccif_i,
  input  logic [2*CH_PAIRS_NUM-1:0] ocref_i,
  input  logic                      trg_ovf_clr_i,
  output logic                      trg_o,
  output logic                      trg_busy_o,
  output logic                      trg_ovf_o
);

  localparam int CH_NUM = 2 * CH_PAIRS_NUM;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PULSE_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]     pending_q, pending_d;
  logic                 ovf_q, ovf_set;
  logic [2:0]           mms_q;
  logic                 msm_q;
  logic                 ccif0_q;
  logic                 level_q;
  logic                 delay_q;

  logic                 mode_chg;
  logic                 pulse_mode;
  logic                 ccif_rise;
  logic                 event_raw;
  logic                 level_sel;
  logic                 ev;
  logic                 stage0;

  // Only channel 0 feeds the compare-pulse mode; the other flags are
  // collected here so they are visibly consumed.
  logic                 unused_ccif;
  assign unused_ccif = ^ccif_i[CH_NUM-1:1];

  function automatic logic is_pulse_mode(input logic [2:0] m);
    return (m == 3'b000) || (m == 3'b010) || (m == 3'b011);
  endfunction

  // A mode change is detected against the registered previous mode; in that
  // cycle every event is ignored so the new mode starts from a clean slate.
  assign mode_chg   = (mms_i != mms_q);
  assign pulse_mode = is_pulse_mode(mms_i);
  assign ccif_rise  = ccif_i[0] & ~ccif0_q;
  assign ev         = event_raw & ~mode_chg;

  // Select the raw pulse event or the raw level for the current mode. OCxREF
  // indices beyond the implemented channel count read as 0.
  always_comb begin
    event_raw = 1'b0;
    level_sel = 1'b0;
    case (mms_i)
      3'b000:  event_raw = ug_i;
      3'b001:  level_sel = cen_i;
      3'b010:  event_raw = uev_i;
      3'b011:  event_raw = ccif_rise;
      default: begin
        for (int i = 0; i < CH_NUM; i++) begin
          if ((i < 4) && (mms_i[1:0] == i[1:0])) begin
            level_sel = ocref_i[i];
          end
        end
      end
    endcase
  end

  // Pulse engine next-state logic. In GAP an arriving event counts as the
  // one being dequeued, so a new pulse starts whenever the queue holds
  // something or an event shows up, and the queue depth stays unchanged when
  // both happen together.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (!pulse_mode || mode_chg) begin
      state_d   = IDLE;
      cnt_d     = '0;
      pending_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev) begin
            state_d = PULSE;
            cnt_d   = pw_i;
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            state_d = GAP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
          if (ev) begin
            if (pending_q == PEND_MAX) begin
              ovf_set = 1'b1;
            end else begin
              pending_d = pending_q + 1'b1;
            end
          end
        end
        GAP: begin
          if ((pending_q != '0) || ev) begin
            state_d = PULSE;
            cnt_d   = pw_i;
            if (!ev) begin
              pending_d = pending_q - 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          pending_d = '0;
        end
      endcase
    end
  end

  // The first output stage is already registered: the pulse state in pulse
  // modes, the sampled level in level modes. The mux keys off the registered
  // mode so the cycle after a mode change always sees cleared state.
  assign stage0 = is_pulse_mode(mms_q) ? (state_q == PULSE) : level_q;

  // All state registers. The optional delay stage is flushed on any mode or
  // msm change, so the output shows at most a single low cycle instead of a
  // stale or duplicated value.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      mms_q     <= 3'b000;
      msm_q     <= 1'b0;
      ccif0_q   <= 1'b0;
      level_q   <= 1'b0;
      delay_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      mms_q     <= mms_i;
      msm_q     <= msm_i;
      ccif0_q   <= mode_chg ? 1'b0 : ccif_i[0];
      level_q   <= mode_chg ? 1'b0 : level_sel;
      delay_q   <= (mode_chg || (msm_i != msm_q)) ? 1'b0 : stage0;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (trg_ovf_clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign trg_o      = msm_q ? delay_q : stage0;
  assign trg_busy_o = (state_q != IDLE) || (pending_q != '0);
  assign trg_ovf_o  = ovf_q;

endmodule

// File: tb/tb_master_mode_controller.sv
// tb_master_mode_controller
// Directed bench for master_mode_controller. A table of per-cycle input
// records with hand-computed expected outputs covers reset, the update and
// reset-mode pulse trains and the level modes. Hand-written sequences cover
// queue overflow, a mode change mid-pulse, reset mid-pulse and msm switching.
module tb_master_mode_controller;

  typedef struct {
    logic       srst;
    logic [2:0] mms;
    logic       msm;
    logic [3:0] pw;
    logic       ug;
    logic       cen;
    logic       uev;
    logic [3:0] ccif;
    logic [3:0] ocref;
    logic       clr;
    logic       exp_trg;
    logic       exp_busy;
    logic       exp_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [2:0] mms = 3'b000;
  logic       msm = 1'b0;
  logic [3:0] pw = 4'd0;
  logic       ug = 1'b0;
  logic       cen = 1'b0;
  logic       uev = 1'b0;
  logic [3:0] ccif = 4'd0;
  logic [3:0] ocref = 4'd0;
  logic       trg_ovf_clr = 1'b0;
  logic       trg;
  logic       trg_busy;
  logic       trg_ovf;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  vec_t cur;

  master_mode_controller #(
    .CH_PAIRS_NUM(2),
    .PULSE_W(4),
    .CNT_W(3)
  ) dut (
    .clk_i(clk),
    .srst_i(srst),
    .mms_i(mms),
    .msm_i(msm),
    .pw_i(pw),
    .ug_i(ug),
    .cen_i(cen),
    .uev_i(uev),
    .ccif_i(ccif),
    .ocref_i(ocref),
    .trg_ovf_clr_i(trg_ovf_clr),
    .trg_o(trg),
    .trg_busy_o(trg_busy),
    .trg_ovf_o(trg_ovf)
  );

  // Free-running kernel clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Safety net so the run always ends even if a wait misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic s, input logic [2:0] m, input logic ms,
                              input logic [3:0] p, input logic u, input logic c,
                              input logic e, input logic [3:0] o,
                              input logic t, input logic b, input logic v);
    vec_t r;
    r.srst = s;  r.mms = m;  r.msm = ms;  r.pw = p;
    r.ug = u;    r.cen = c;  r.uev = e;   r.ccif = 4'd0;
    r.ocref = o; r.clr = 1'b0;
    r.exp_trg = t; r.exp_busy = b; r.exp_ovf = v;
    return r;
  endfunction

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge where the registered outputs of that cycle are stable.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    srst        = v.srst;
    mms         = v.mms;
    msm         = v.msm;
    pw          = v.pw;
    ug          = v.ug;
    cen         = v.cen;
    uev         = v.uev;
    ccif        = v.ccif;
    ocref       = v.ocref;
    trg_ovf_clr = v.clr;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  initial begin
    // Reset, update-mode pulse with pw=2 (uev in vector 4)
    vecs.push_back(mk(1, 3'b010, 0, 4'd2, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 0, 4'd2, 0, 0, 1, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 0, 4'd2, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 0, 4'd2, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 0, 4'd2, 0, 0, 1, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 0, 4'd2, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 3'b010, 0, 4'd2, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 3'b010, 0, 4'd2, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 3'b010, 0, 4'd2, 0, 0, 0, 4'h0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b010, 0, 4'd2, 0, 0, 0, 4'h0, 0, 0, 0));
    // Reset mode, pw=0, ug high three cycles in a row (vectors 12-14)
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 1, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 1, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 1, 0, 0, 4'h0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 0, 0, 0, 4'h0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 0, 0, 0, 4'h0, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 0, 0, 0, 4'h0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 4'd0, 0, 0, 0, 4'h0, 0, 0, 0));
    // Enable mode with msm=1: cen rises in vector 23, trg_o rises in 25
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 1, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 1, 0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 1, 0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 0, 0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 0, 0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 4'd0, 0, 0, 0, 4'h0, 0, 0, 0));
    // OC2REF level mode, msm=0: trg_o follows ocref[1] one cycle later
    vecs.push_back(mk(0, 3'b101, 0, 4'd0, 0, 0, 0, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 3'b101, 0, 4'd0, 0, 0, 0, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 3'b101, 0, 4'd0, 0, 0, 0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b101, 0, 4'd0, 0, 0, 0, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 3'b101, 0, 4'd0, 0, 0, 0, 4'hD, 1, 0, 0));
    vecs.push_back(mk(0, 3'b101, 0, 4'd0, 0, 0, 0, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 3'b101, 0, 4'd0, 0, 0, 0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b101, 0, 4'd0, 0, 0, 0, 4'h0, 0, 0, 0));

    $display("[TB] starting, %0d table vectors", vecs.size());

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d trg", i), trg, vecs[i].exp_trg);
      checkOutput($sformatf("vec%0d busy", i), trg_busy, vecs[i].exp_busy);
      checkOutput($sformatf("vec%0d ovf", i), trg_ovf, vecs[i].exp_ovf);
    end

    // Compare-pulse mode, pw=7: ccif[0] rises every other cycle. The queue
    // fills to 7 by cycle 16; the rise at 20 is dropped and sets the flag.
    // A clear together with another drop (cycle 22) leaves the flag set.
    cur = mk(0, 3'b011, 0, 4'd7, 0, 0, 0, 4'h0, 0, 0, 0);
    applyStimulus(cur);
    applyStimulus(cur);
    for (int k = 0; k <= 22; k++) begin
      cur.ccif = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      cur.clr  = (k == 22);
      applyStimulus(cur);
      if (k == 1)  checkOutput("ovfseq first pulse trg", trg, 1'b1);
      if (k == 9)  checkOutput("ovfseq gap trg", trg, 1'b0);
      if (k == 9)  checkOutput("ovfseq gap busy", trg_busy, 1'b1);
      if (k == 10) checkOutput("ovfseq second pulse trg", trg, 1'b1);
      if (k == 17) checkOutput("ovfseq queue full no ovf", trg_ovf, 1'b0);
      if (k == 21) checkOutput("ovfseq drop sets ovf", trg_ovf, 1'b1);
    end
    cur.ccif = 4'b0000;
    cur.clr  = 1'b1;
    applyStimulus(cur);
    checkOutput("ovfseq set beats clear", trg_ovf, 1'b1);
    cur.clr = 1'b0;
    applyStimulus(cur);
    checkOutput("ovfseq clear alone", trg_ovf, 1'b0);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(cur);
      if (!trg_busy) break;
    end
    checkOutput("ovfseq drain busy", trg_busy, 1'b0);

    // Update mode, pw=5, three events queue two behind the first pulse; the
    // switch to OC1REF mid-pulse gives a low cycle, an empty queue and then
    // ocref[0] tracking.
    cur = mk(0, 3'b010, 0, 4'd5, 0, 0, 0, 4'h0, 0, 0, 0);
    applyStimulus(cur);
    applyStimulus(cur);
    for (int k = 0; k <= 9; k++) begin
      cur.uev = (k == 0) || (k == 2) || (k == 4);
      if (k >= 5) cur.mms = 3'b100;
      cur.ocref = ((k == 5) || (k == 6)) ? 4'b0001 : 4'b0000;
      applyStimulus(cur);
      if (k == 5) checkOutput("modechg before trg", trg, 1'b1);
      if (k == 5) checkOutput("modechg before busy", trg_busy, 1'b1);
      if (k == 6) checkOutput("modechg after trg", trg, 1'b0);
      if (k == 6) checkOutput("modechg after busy", trg_busy, 1'b0);
      if (k == 7) checkOutput("modechg level high", trg, 1'b1);
      if (k == 8) checkOutput("modechg level low", trg, 1'b0);
      if (k == 9) checkOutput("modechg level stays", trg, 1'b0);
    end

    // Reset in the middle of a pw=7 pulse with three events queued; uev
    // asserted during and right after reset must not create a pulse.
    cur = mk(0, 3'b010, 0, 4'd7, 0, 0, 0, 4'h0, 0, 0, 0);
    applyStimulus(cur);
    applyStimulus(cur);
    for (int k = 0; k <= 11; k++) begin
      cur.uev  = (k == 0) || (k == 2) || (k == 4) || (k == 6) || (k == 7) || (k == 8) || (k == 9);
      cur.srst = (k == 7) || (k == 8);
      applyStimulus(cur);
      if (k == 7)  checkOutput("rstseq pulse before reset", trg, 1'b1);
      if (k == 7)  checkOutput("rstseq busy before reset", trg_busy, 1'b1);
      if (k == 8)  checkOutput("rstseq trg after reset", trg, 1'b0);
      if (k == 8)  checkOutput("rstseq busy after reset", trg_busy, 1'b0);
      if (k == 8)  checkOutput("rstseq ovf after reset", trg_ovf, 1'b0);
      if (k == 10) checkOutput("rstseq no pulse from reset uev", trg, 1'b0);
      if (k == 10) checkOutput("rstseq idle after release", trg_busy, 1'b0);
      if (k == 11) checkOutput("rstseq still quiet", trg, 1'b0);
    end

    // Enable mode with cen held high; toggling msm flushes the delay stage
    // for exactly one low cycle.
    cur = mk(0, 3'b001, 0, 4'd0, 0, 1, 0, 4'h0, 0, 0, 0);
    applyStimulus(cur);
    for (int k = 1; k <= 6; k++) begin
      cur.msm = (k == 2) || (k == 3);
      applyStimulus(cur);
      if (k == 1) checkOutput("msmseq after mode change", trg, 1'b0);
      if (k == 2) checkOutput("msmseq level high", trg, 1'b1);
      if (k == 3) checkOutput("msmseq flush low", trg, 1'b0);
      if (k == 4) checkOutput("msmseq delayed high", trg, 1'b1);
      if (k == 5) checkOutput("msmseq back to direct", trg, 1'b1);
      if (k == 6) checkOutput("msmseq steady", trg, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
